mb_load_sched: RTL and testbench
================================

Name: mb_load_sched

Overview:
- Controller for the MB (memory buffer) word datapath.
- Arbitrates four requesters for the four-word MB: memory read return, cache writeback, channel buffer and EBOX/AR store.
- Sequences word loads one word per cycle and drives the MB input-select code and per-word hold lines.
- Hands a full MB to the unload side (memory write or cache fill) with a ready/ack handshake.

Parameters:
- NREQ, 4, number of requesters; fixed priority index 0 highest.
- WORDS, 4, MB words per group; must be a power of two.
- STARVE_MAX, 7, cycles a pending requester may be bypassed before it is promoted (MB_FAIR_ARB_EN only).

Ports:
- clk  in  1  board clock; every flop on rising edge.
- reset_l  in  1  synchronous active-low reset.
- req_h  in  NREQ  load request: 0=mem read, 1=cache wb, 2=channel, 3=AR store.
- req_first_word_h  in  NREQ*2  starting MB word per requester.
- req_count_h  in  NREQ*3  words to load, 1..WORDS; 0 is treated as 1.
- gnt_h  out  NREQ  one-hot grant, held for the whole burst.
- word_strobe_h  in  1  granted source presents its next word this cycle.
- mb_in_sel_h  out  3  MB mux select: 0=hold, 1=AR, 2=cache data, 3=mem data, 4=ch buf.
- mb_hold_h  out  WORDS  per-word hold; low only on the word being loaded.
- nxm_any_l  in  1  nonexistent-memory abort, active low.
- mb_full_h  out  1  group loaded, offered to the unload side.
- mb_unload_ack_h  in  1  consumer has taken the group.
- mb_word_valid_h  out  WORDS  per-word valid bits.
- sched_err_h  out  1  sticky: strobe with no grant, or an NXM abort occurred.

Behaviour:
- Reset (reset_l low at an edge): state IDLE, gnt_h=0, mb_in_sel_h=0, mb_hold_h all 1, mb_full_h=0, mb_word_valid_h=0, sched_err_h=0, all counters 0.
- Reset mid-burst abandons the burst; valid bits are cleared.
- State IDLE:
  - Any req_h high: latch the winner by fixed priority, its start word and its count.
  - Assert gnt_h on the next cycle and go to LOAD.
  - Arbitration latency is 1 cycle from req to gnt.
- State LOAD:
  - gnt_h is stable.
  - On a cycle with word_strobe_h: mb_hold_h[cur]=0, mb_in_sel_h = source code, mb_word_valid_h[cur] set at the edge.
  - cur advances modulo WORDS, so start word 2 with count 4 loads 2,3,0,1. Remaining count decrements.
  - Cycles without a strobe: mb_in_sel_h=0 and all holds high.
  - When the last word is taken: drop gnt_h the next cycle and go to FULL.
- State FULL:
  - mb_full_h=1 and no grants are issued.
  - On mb_unload_ack_h: clear valids and mb_full_h, then go to IDLE.
  - An ack is honoured only in FULL; an ack in any other state is ignored.
- A new request arriving while in LOAD or FULL waits and is arbitrated in IDLE. There is no preemption.
- NXM abort: nxm_any_l low in LOAD while requester 0 is granted:
  - burst terminates that cycle;
  - any word loaded that cycle is still taken;
  - go to FULL with partial valids;
  - set sched_err_h.
- word_strobe_h in IDLE or FULL: ignored, sched_err_h set.
- Simultaneous strobe and NXM: the word is loaded, then the abort applies.
- sched_err_h clears only on reset.

Optional Feature:
- MB_FAIR_ARB_EN defined:
  - Each requester has a saturating 3-bit bypass counter, incremented when it is pending but not granted in IDLE.
  - A counter at STARVE_MAX wins over fixed priority; among several, the lowest index wins.
  - The winner's counter is cleared on grant.
- Not defined: pure fixed priority and no counters are built.

Decomposition:
- Package mb_sched_pkg holds:
  - the mb_in_sel code localparams (SEL_HOLD, SEL_AR, SEL_CACHE, SEL_MEM, SEL_CHBUF);
  - the state enum (IDLE, LOAD, FULL);
  - the requester index constants.
- One natural sub-module, mb_req_arb: combinational priority pick, plus the starvation counters under MB_FAIR_ARB_EN.
- Sequencing and word pointer stay in the top module.

Test Plan:
- Reset mid-LOAD after 2 of 4 words -> next cycle all outputs at reset values, valids 0.
- req_h=4'b1000, start 2, count 4, strobes every cycle -> gnt_h=1000 one cycle after req; hold lows on words 2,3,0,1; mb_in_sel_h=1 (AR) on each load cycle; mb_full_h=1 with valids 1111.
- req_h=4'b0101 together -> requester 0 granted with mem_in_sel=3; requester 2 granted only after ack; a strobe gap mid-burst gives sel 0 and all holds high.
- Mem read count 4, nxm_any_l low on the 2nd strobe -> valids for the 2 words loaded, mb_full_h=1, sched_err_h=1.
- Ack in LOAD -> no effect; strobe in IDLE -> sched_err_h=1, no valid change.
- MB_FAIR_ARB_EN: requester 0 asserted continuously and requester 3 pending -> requester 3 granted after 7 bypasses; without the macro it is never granted.

Source files
------------

// File: rtl/mb_sched_pkg.sv
// Shared MB scheduler definitions: mux select codes, states, requester ids.
package mb_sched_pkg;

  localparam logic [2:0] SEL_HOLD  = 3'd0;
  localparam logic [2:0] SEL_AR    = 3'd1;
  localparam logic [2:0] SEL_CACHE = 3'd2;
  localparam logic [2:0] SEL_MEM   = 3'd3;
  localparam logic [2:0] SEL_CHBUF = 3'd4;

  localparam int REQ_MEM  = 0;
  localparam int REQ_CWB  = 1;
  localparam int REQ_CHAN = 2;
  localparam int REQ_AR   = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    FULL = 2'd2
  } state_e;

  function automatic logic [2:0] src_sel(input logic [1:0] idx);
    logic [2:0] s;
    s = SEL_HOLD;
    case (int'(idx))
      REQ_MEM:  s = SEL_MEM;
      REQ_CWB:  s = SEL_CACHE;
      REQ_CHAN: s = SEL_CHBUF;
      REQ_AR:   s = SEL_AR;
      default:  s = SEL_HOLD;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/mb_req_arb.sv
// Fixed-priority requester pick for the MB loader.
// MB_FAIR_ARB_EN adds per-requester bypass counters with starvation promotion.
module mb_req_arb #(
  parameter int NREQ = 4
`ifdef MB_FAIR_ARB_EN
  , parameter int STARVE_MAX = 7
`endif
) (
`ifdef MB_FAIR_ARB_EN
  input  logic                    clk,
  input  logic                    reset_l,
  input  logic                    en,
`endif
  input  logic [NREQ-1:0]         req,
  output logic [NREQ-1:0]         win,
  output logic [$clog2(NREQ)-1:0] win_idx,
  output logic                    win_vld
);

  localparam int IW = $clog2(NREQ);

  logic [NREQ-1:0] pool;

`ifdef MB_FAIR_ARB_EN
  logic [2:0]      byp [NREQ];
  logic [NREQ-1:0] starved;

  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      starved[i] = req[i] && (byp[i] == 3'(STARVE_MAX));
    end
  end

  // Any starved requester narrows the pool; lowest index still wins.
  assign pool = (|starved) ? starved : req;

  always_ff @(posedge clk) begin
    for (int i = 0; i < NREQ; i++) begin
      if (!reset_l) begin
        byp[i] <= 3'd0;
      end else if (en && win_vld) begin
        if (win[i]) begin
          byp[i] <= 3'd0;
        end else if (req[i] && byp[i] != 3'(STARVE_MAX)) begin
          byp[i] <= byp[i] + 3'd1;
        end
      end
    end
  end
`else
  assign pool = req;
`endif

  always_comb begin
    win     = '0;
    win_idx = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (pool[i]) begin
        win     = '0;
        win[i]  = 1'b1;
        win_idx = IW'(i);
      end
    end
  end

  assign win_vld = |req;

endmodule

// File: rtl/mb_load_sched.sv
// MB word-load scheduler: arbitration, word sequencing, unload handoff.
// MB_FAIR_ARB_EN enables starvation promotion in the requester arbiter.
module mb_load_sched
  import mb_sched_pkg::*;
#(
  parameter int NREQ       = 4,
  parameter int WORDS      = 4,
  parameter int STARVE_MAX = 7
) (
  input  logic              clk,
  input  logic              reset_l,
  input  logic [NREQ-1:0]   req_h,
  input  logic [NREQ*2-1:0] req_first_word_h,
  input  logic [NREQ*3-1:0] req_count_h,
  output logic [NREQ-1:0]   gnt_h,
  input  logic              word_strobe_h,
  output logic [2:0]        mb_in_sel_h,
  output logic [WORDS-1:0]  mb_hold_h,
  input  logic              nxm_any_l,
  output logic              mb_full_h,
  input  logic              mb_unload_ack_h,
  output logic [WORDS-1:0]  mb_word_valid_h,
  output logic              sched_err_h
);

  localparam int PW = $clog2(WORDS);
  localparam int IW = $clog2(NREQ);
  localparam int CW = PW + 1;

  if (((WORDS & (WORDS - 1)) != 0) || STARVE_MAX > 7) begin : g_cfg_bad
    $error("mb_load_sched: WORDS must be 2^n, STARVE_MAX <= 7");
  end

  state_e          state;
  logic [PW-1:0]   cur;
  logic [CW-1:0]   rem;
  logic [IW-1:0]   src;
  logic [NREQ-1:0] win;
  logic [IW-1:0]   win_idx;
  logic            win_vld;
  logic [1:0]      win_first;
  logic [2:0]      win_cnt;
  logic [CW-1:0]   burst_len;
  logic            take;
  logic            last;
  logic            abort;

  mb_req_arb #(
    .NREQ(NREQ)
`ifdef MB_FAIR_ARB_EN
    , .STARVE_MAX(STARVE_MAX)
`endif
  ) u_arb (
`ifdef MB_FAIR_ARB_EN
    .clk     (clk),
    .reset_l (reset_l),
    .en      (state == IDLE),
`endif
    .req     (req_h),
    .win     (win),
    .win_idx (win_idx),
    .win_vld (win_vld)
  );

  assign win_first = req_first_word_h[int'(win_idx)*2 +: 2];
  assign win_cnt   = req_count_h[int'(win_idx)*3 +: 3];

  // Zero means one word; anything past the group size is clipped.
  always_comb begin
    burst_len = CW'(win_cnt);
    if (win_cnt == 3'd0) begin
      burst_len = CW'(1);
    end else if (int'(win_cnt) > WORDS) begin
      burst_len = CW'(WORDS);
    end
  end

  assign take      = (state == LOAD) && word_strobe_h;
  assign abort     = (state == LOAD) && !nxm_any_l && gnt_h[REQ_MEM];
  assign last      = take && (rem == CW'(1));
  assign mb_full_h = (state == FULL);

  assign mb_in_sel_h = take ? src_sel(src) : SEL_HOLD;

  always_comb begin
    mb_hold_h = '1;
    if (take) begin
      mb_hold_h[cur] = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_l) begin
      state           <= IDLE;
      gnt_h           <= '0;
      cur             <= '0;
      rem             <= '0;
      src             <= '0;
      mb_word_valid_h <= '0;
      sched_err_h     <= 1'b0;
    end else begin
      if (abort || (word_strobe_h && state != LOAD)) begin
        sched_err_h <= 1'b1;
      end
      unique case (state)
        IDLE: begin
          if (win_vld) begin
            gnt_h <= win;
            src   <= win_idx;
            cur   <= PW'(win_first);
            rem   <= burst_len;
            state <= LOAD;
          end
        end
        LOAD: begin
          if (take) begin
            mb_word_valid_h[cur] <= 1'b1;
            cur                  <= cur + 1'b1;
            rem                  <= rem - 1'b1;
          end
          if (last || abort) begin
            gnt_h <= '0;
            state <= FULL;
          end
        end
        FULL: begin
          if (mb_unload_ack_h) begin
            mb_word_valid_h <= '0;
            state           <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mb_load_sched.sv
// Self-checking bench for mb_load_sched: directed cases plus random bursts
// against a burst-level model of arbitration, word order and error rules.
module tb_mb_load_sched;

  logic        clk = 1'b0;
  logic        reset_l = 1'b0;
  logic [3:0]  req_h = '0;
  logic [7:0]  req_first_word_h;
  logic [11:0] req_count_h;
  logic [3:0]  gnt_h;
  logic        word_strobe_h = 1'b0;
  logic [2:0]  mb_in_sel_h;
  logic [3:0]  mb_hold_h;
  logic        nxm_any_l = 1'b1;
  logic        mb_full_h;
  logic        mb_unload_ack_h = 1'b0;
  logic [3:0]  mb_word_valid_h;
  logic        sched_err_h;

  logic [1:0]  fw  [4];
  logic [2:0]  cnt [4];

  assign req_first_word_h = {fw[3], fw[2], fw[1], fw[0]};
  assign req_count_h      = {cnt[3], cnt[2], cnt[1], cnt[0]};

  mb_load_sched dut (
    .clk              (clk),
    .reset_l          (reset_l),
    .req_h            (req_h),
    .req_first_word_h (req_first_word_h),
    .req_count_h      (req_count_h),
    .gnt_h            (gnt_h),
    .word_strobe_h    (word_strobe_h),
    .mb_in_sel_h      (mb_in_sel_h),
    .mb_hold_h        (mb_hold_h),
    .nxm_any_l        (nxm_any_l),
    .mb_full_h        (mb_full_h),
    .mb_unload_ack_h  (mb_unload_ack_h),
    .mb_word_valid_h  (mb_word_valid_h),
    .sched_err_h      (sched_err_h)
  );

  always #5 clk = ~clk;

`ifdef MB_FAIR_ARB_EN
  localparam bit FAIR = 1'b1;
`else
  localparam bit FAIR = 1'b0;
`endif

  int         ntest = 0;
  int         nfail = 0;
  logic [3:0] m_valid = '0;
  logic       m_err = 1'b0;
  int         starve [4];

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    ntest++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [2:0] code(input int w);
    case (w)
      0:       return 3'd3;
      1:       return 3'd2;
      2:       return 3'd4;
      default: return 3'd1;
    endcase
  endfunction

  function automatic int pick(input logic [3:0] r);
    if (FAIR) begin
      for (int i = 0; i < 4; i++) if (r[i] && starve[i] >= 7) return i;
    end
    for (int i = 0; i < 4; i++) if (r[i]) return i;
    return -1;
  endfunction

  task automatic chk_quiet(input string tag);
    chk({tag, "_gnt"}, gnt_h, 0);
    chk({tag, "_sel"}, mb_in_sel_h, 0);
    chk({tag, "_hold"}, mb_hold_h, 4'hf);
    chk({tag, "_full"}, mb_full_h, 0);
    chk({tag, "_valid"}, mb_word_valid_h, m_valid);
    chk({tag, "_err"}, sched_err_h, m_err);
  endtask

  task automatic model_reset();
    m_valid = '0;
    m_err   = 1'b0;
    for (int i = 0; i < 4; i++) starve[i] = 0;
  endtask

  task automatic do_reset();
    reset_l = 1'b0;
    req_h = '0;
    word_strobe_h = 1'b0;
    nxm_any_l = 1'b1;
    mb_unload_ack_h = 1'b0;
    tick();
    tick();
    reset_l = 1'b1;
    model_reset();
    #1;
    chk_quiet("reset");
  endtask

  // One grant-load-unload cycle starting from IDLE with req_h already set.
  task automatic burst(input bit keep, input int gap_pct, input bit force_gap,
                       input int nxm_at, input bit ack_mid,
                       input bit strobe_full, output logic [3:0] g);
    int w, pos, left, taken, it;
    bit done, ab;
    logic [3:0] hexp;
    chk("gnt_latency", gnt_h, 0);
    w = pick(req_h);
    if (FAIR) begin
      for (int i = 0; i < 4; i++) begin
        if (i == w) starve[i] = 0;
        else if (req_h[i] && starve[i] < 7) starve[i]++;
      end
    end
    pos  = int'(fw[w]);
    left = (cnt[w] == 0) ? 1 : int'(cnt[w]);
    tick();
    g = gnt_h;
    chk("gnt", gnt_h, 4'b1 << w);
    if (!keep) req_h[w] = 1'b0;
    done = 0;
    it = 0;
    taken = 0;
    while (!done && it < 64) begin
      it++;
      mb_unload_ack_h = ack_mid;
      if ((force_gap && it == 2) ||
          (it < 32 && int'($urandom_range(99)) < gap_pct)) begin
        word_strobe_h = 1'b0;
        nxm_any_l = 1'b1;
        #1;
        chk("gap_sel", mb_in_sel_h, 0);
        chk("gap_hold", mb_hold_h, 4'hf);
        chk("gap_gnt", gnt_h, 4'b1 << w);
        chk("gap_full", mb_full_h, 0);
        tick();
      end else begin
        word_strobe_h = 1'b1;
        nxm_any_l = (nxm_at == taken) ? 1'b0 : 1'b1;
        hexp = 4'hf;
        hexp[pos] = 1'b0;
        #1;
        chk("load_hold", mb_hold_h, hexp);
        chk("load_sel", mb_in_sel_h, code(w));
        ab = !nxm_any_l && (w == 0);
        tick();
        m_valid[pos] = 1'b1;
        pos = (pos + 1) % 4;
        left--;
        taken++;
        if (ab) m_err = 1'b1;
        done = (left == 0) || ab;
      end
    end
    chk("burst_done", 32'(done), 1);
    word_strobe_h = 1'b0;
    nxm_any_l = 1'b1;
    mb_unload_ack_h = 1'b0;
    #1;
    chk("full_gnt", gnt_h, 0);
    chk("full", mb_full_h, 1);
    chk("full_valid", mb_word_valid_h, m_valid);
    chk("full_err", sched_err_h, m_err);
    if (strobe_full) begin
      word_strobe_h = 1'b1;
      #1;
      chk("fstb_sel", mb_in_sel_h, 0);
      chk("fstb_hold", mb_hold_h, 4'hf);
      tick();
      word_strobe_h = 1'b0;
      m_err = 1'b1;
      chk("fstb_err", sched_err_h, m_err);
      chk("fstb_valid", mb_word_valid_h, m_valid);
      chk("fstb_full", mb_full_h, 1);
    end
    mb_unload_ack_h = 1'b1;
    tick();
    mb_unload_ack_h = 1'b0;
    m_valid = '0;
    #1;
    chk("ack_full", mb_full_h, 0);
    chk("ack_valid", mb_word_valid_h, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] g;
    int first3;
    for (int i = 0; i < 4; i++) begin
      fw[i]  = '0;
      cnt[i] = 3'd1;
    end
    do_reset();

    // Reset in the middle of a four-word load.
    req_h = 4'b0010;
    cnt[1] = 3'd4;
    tick();
    req_h = '0;
    chk("mid_gnt", gnt_h, 4'b0010);
    word_strobe_h = 1'b1;
    tick();
    tick();
    chk("mid_valid", mb_word_valid_h, 4'b0011);
    reset_l = 1'b0;
    word_strobe_h = 1'b0;
    tick();
    reset_l = 1'b1;
    model_reset();
    #1;
    chk_quiet("mid_reset");

    // AR store, start word 2, four words back to back.
    req_h = 4'b1000;
    fw[3] = 2'd2;
    cnt[3] = 3'd4;
    burst(1'b0, 0, 1'b0, -1, 1'b0, 1'b0, g);

    // Mem read and channel together; channel waits for the unload.
    req_h = 4'b0101;
    fw[0] = 2'd1;
    cnt[0] = 3'd3;
    fw[2] = 2'd3;
    cnt[2] = 3'd2;
    burst(1'b0, 0, 1'b1, -1, 1'b0, 1'b0, g);
    chk("wait_req", req_h, 4'b0100);
    burst(1'b0, 0, 1'b0, -1, 1'b0, 1'b0, g);

    // NXM on the second mem strobe.
    req_h = 4'b0001;
    fw[0] = 2'd0;
    cnt[0] = 3'd4;
    burst(1'b0, 0, 1'b0, 1, 1'b0, 1'b0, g);
    do_reset();

    // Ack held through LOAD, then a stray strobe in IDLE.
    req_h = 4'b0100;
    fw[2] = 2'd1;
    cnt[2] = 3'd0;
    burst(1'b0, 50, 1'b1, -1, 1'b1, 1'b0, g);
    word_strobe_h = 1'b1;
    #1;
    chk("istb_sel", mb_in_sel_h, 0);
    chk("istb_hold", mb_hold_h, 4'hf);
    tick();
    word_strobe_h = 1'b0;
    m_err = 1'b1;
    #1;
    chk_quiet("istb");

    // Mem read hogs the bus while AR store waits.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      fw[i]  = '0;
      cnt[i] = 3'd1;
    end
    req_h = 4'b1001;
    first3 = -1;
    for (int k = 0; k < 10; k++) begin
      burst(1'b1, 0, 1'b0, -1, 1'b0, 1'b0, g);
      if (g[3] && first3 < 0) first3 = k;
    end
    chk("fair_first3", first3, FAIR ? 7 : -1);

    // Random bursts against the model.
    do_reset();
    for (int k = 0; k < 40; k++) begin
      req_h = req_h | 4'($urandom_range(1, 15));
      for (int i = 0; i < 4; i++) begin
        fw[i]  = 2'($urandom_range(3));
        cnt[i] = 3'($urandom_range(4));
      end
      burst(1'b0, 30, 1'b0,
            ($urandom_range(3) == 0) ? int'($urandom_range(3)) : -1,
            1'($urandom_range(1)), ($urandom_range(3) == 0), g);
    end

    $display("[TB] %0d tests run, %0d failed", ntest, nfail);
    $finish;
  end

endmodule
